vector_sweeper: RTL and testbench

- Parametrised, self-checking exhaustive stimulus sequencer for small combinational blocks.
- Drives every input combination 0 .. 2^N_IN-1 in ascending order and holds each for HOLD clock cycles.
- On the last hold cycle it compares the DUT response against a reference-model response, counts mismatches and records the first failing vector.
- Sits beside the DUT and its golden model inside bench/BIST wrappers. Replaces hand-written 16-step stimulus lists with one synthesizable block.

---
 rtl/sweep_pkg.sv | 28 ++
 rtl/sweep_scoreboard.sv | 88 ++++++++
 rtl/vector_sweeper.sv | 146 ++++++++++++++
 tb/tb_vector_sweeper.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and helpers for the exhaustive vector sweeper.
package sweep_pkg;

  // Sweeper control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Shortest hold that still leaves one cycle between vector change and compare.
  localparam int MIN_HOLD = 2;

  // Bits needed to count 0 .. value-1 (at least 1 bit for any value >= 2).
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sweep_scoreboard.sv
// Compare register, saturating mismatch counter and first-fail latch.
module sweep_scoreboard
  import sweep_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              cmp_en_i,
  input  logic [N_IN-1:0]   vec_i,
  input  logic [N_OUT-1:0]  dut_resp_i,
  input  logic [N_OUT-1:0]  exp_resp_i,
  output logic              sample_valid_o,
  output logic              sample_fail_o,
  output logic [N_IN:0]     mismatch_cnt_o,
  output logic              first_fail_valid_o,
  output logic [N_IN-1:0]   first_fail_vec_o
);

  localparam logic [N_IN:0] CNT_MAX = {(N_IN+1){1'b1}};
  localparam logic [N_IN:0] CNT_ONE = {{N_IN{1'b0}}, 1'b1};

  logic            fail_s;
  logic            valid_q, valid_d;
  logic            fail_q, fail_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;

  assign fail_s = (dut_resp_i != exp_resp_i);

  // Next values: sample pulse, counter update and first-fail capture.
  always_comb begin
    valid_d = cmp_en_i;
    fail_d  = cmp_en_i && fail_s;
    cnt_d   = cnt_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    if (clear_i) begin
      cnt_d   = {(N_IN+1){1'b0}};
      ffv_d   = 1'b0;
      ffvec_d = {N_IN{1'b0}};
    end else if (cmp_en_i && fail_s) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
      if (!ffv_q) begin
        ffv_d   = 1'b1;
        ffvec_d = vec_i;
      end else begin
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
      end
    end else begin
      cnt_d   = cnt_q;
      ffv_d   = ffv_q;
      ffvec_d = ffvec_q;
    end
  end

  // Scoreboard registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      fail_q  <= 1'b0;
      cnt_q   <= {(N_IN+1){1'b0}};
      ffv_q   <= 1'b0;
      ffvec_q <= {N_IN{1'b0}};
    end else begin
      valid_q <= valid_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign sample_valid_o     = valid_q;
  assign sample_fail_o      = fail_q;
  assign mismatch_cnt_o     = cnt_q;
  assign first_fail_valid_o = ffv_q;
  assign first_fail_vec_o   = ffvec_q;

endmodule

// File: rtl/vector_sweeper.sv
// Exhaustive stimulus sequencer: walks every input vector, holds each for
// HOLD cycles and scores the DUT against its golden model on the last cycle.
module vector_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int HOLD  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              loop_i,
  output logic [N_IN-1:0]   vec_out_o,
  input  logic [N_OUT-1:0]  dut_resp_i,
  input  logic [N_OUT-1:0]  exp_resp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              sample_valid_o,
  output logic              sample_fail_o,
  output logic [N_IN:0]     mismatch_cnt_o,
  output logic              first_fail_valid_o,
  output logic [N_IN-1:0]   first_fail_vec_o
);

  // A hold shorter than the minimum is raised to the minimum.
  localparam int              HOLD_C    = (HOLD < MIN_HOLD) ? MIN_HOLD : HOLD;
  localparam int              HW        = clog2(HOLD_C);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_C - 1);
  localparam logic [HW-1:0]   HOLD_ONE  = HW'(1'b1);
  localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1'b1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            start_ok_s;
  logic            last_hold_s;
  logic            last_vec_s;

  assign start_ok_s  = start_i && (state_q != DRIVE);
  assign last_hold_s = (state_q == DRIVE) && (hold_q == HOLD_LAST);
  assign last_vec_s  = (vec_q == VEC_LAST);

  // State register plus registered stimulus and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= {N_IN{1'b0}};
      hold_q  <= {HW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state: start leaves IDLE/DONE, last compare of a non-looping sweep ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = DRIVE;
        else         state_d = IDLE;
      end
      DRIVE: begin
        if (last_hold_s && last_vec_s && !loop_i) state_d = DONE;
        else                                      state_d = DRIVE;
      end
      DONE: begin
        if (start_i) state_d = DRIVE;
        else         state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values: vector/hold counters and the busy/done levels.
  always_comb begin
    vec_d  = vec_q;
    hold_d = hold_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          vec_d  = {N_IN{1'b0}};
          hold_d = {HW{1'b0}};
        end else begin
          vec_d  = vec_q;
          hold_d = hold_q;
        end
      end
      DRIVE: begin
        if (last_hold_s) begin
          hold_d = {HW{1'b0}};
          if (!last_vec_s) begin
            vec_d = vec_q + VEC_ONE;
          end else if (loop_i) begin
            vec_d = {N_IN{1'b0}};
          end else begin
            vec_d = vec_q;
          end
        end else begin
          hold_d = hold_q + HOLD_ONE;
          vec_d  = vec_q;
        end
      end
      default: begin
        vec_d  = {N_IN{1'b0}};
        hold_d = {HW{1'b0}};
      end
    endcase
    busy_d = (state_d == DRIVE);
    done_d = (state_d == DONE);
  end

  sweep_scoreboard #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_scoreboard (
    .clk                (clk),
    .rst                (rst),
    .clear_i            (start_ok_s),
    .cmp_en_i           (last_hold_s),
    .vec_i              (vec_q),
    .dut_resp_i         (dut_resp_i),
    .exp_resp_i         (exp_resp_i),
    .sample_valid_o     (sample_valid_o),
    .sample_fail_o      (sample_fail_o),
    .mismatch_cnt_o     (mismatch_cnt_o),
    .first_fail_valid_o (first_fail_valid_o),
    .first_fail_vec_o   (first_fail_vec_o)
  );

  assign vec_out_o = vec_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_vector_sweeper.sv
// Bench for vector_sweeper: an elapsed-time model of the sweep is checked
// against the DUT every cycle, plus literal checks for each scenario.
module tb_vector_sweeper;

  localparam int H  = 4;
  localparam int NV = 16;

  logic clk;
  logic rst;
  logic start, loop;
  logic [3:0] vec;
  logic [1:0] dut_resp, exp_resp;
  logic busy, done, sv, sf, ffv;
  logic [4:0] cnt;
  logic [3:0] ffvec;
  int fault;

  logic start2, loop2;
  logic vec2;
  logic dut2, exp2;
  logic busy2, done2, sv2, sf2, ffv2;
  logic [1:0] cnt2;
  logic ffvec2;

  int n_tests, n_fail;
  int busy_cnt, samp_cnt, done_seen, busy2_cnt, samp2_cnt;
  bit chk_en;

  vector_sweeper #(.N_IN(4), .N_OUT(2), .HOLD(H)) u1 (
    .clk(clk), .rst(rst), .start_i(start), .loop_i(loop), .vec_out_o(vec),
    .dut_resp_i(dut_resp), .exp_resp_i(exp_resp), .busy_o(busy), .done_o(done),
    .sample_valid_o(sv), .sample_fail_o(sf), .mismatch_cnt_o(cnt),
    .first_fail_valid_o(ffv), .first_fail_vec_o(ffvec)
  );

  vector_sweeper #(.N_IN(1), .N_OUT(1), .HOLD(2)) u2 (
    .clk(clk), .rst(rst), .start_i(start2), .loop_i(loop2), .vec_out_o(vec2),
    .dut_resp_i(dut2), .exp_resp_i(exp2), .busy_o(busy2), .done_o(done2),
    .sample_valid_o(sv2), .sample_fail_o(sf2), .mismatch_cnt_o(cnt2),
    .first_fail_valid_o(ffv2), .first_fail_vec_o(ffvec2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden block: f = a & b, g = c | d with vector = {a,b,c,d}, response = {f,g}.
  function automatic logic [1:0] gold(input logic [3:0] v);
    return {v[3] & v[2], v[1] | v[0]};
  endfunction

  // Block under test: mode 1 = f stuck-at-0, mode 2 = g inverted.
  function automatic logic [1:0] faulty(input logic [3:0] v, input int mode);
    logic [1:0] r;
    r = gold(v);
    if (mode == 1) r[1] = 1'b0;
    if (mode == 2) r[0] = ~r[0];
    return r;
  endfunction

  always_comb begin
    dut_resp = faulty(vec, fault);
    exp_resp = gold(vec);
  end

  assign dut2 = 1'b0;
  assign exp2 = 1'b0;

  // Model state: cycles elapsed since the start edge drive everything.
  bit         m_active, m_done, m_sv, m_sf, m_ffv;
  int         m_k, m_cnt;
  logic [3:0] m_vec, m_ffvec, m_s;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_done = 1'b0; m_k = 0; m_vec = 4'd0;
      m_sv = 1'b0; m_sf = 1'b0; m_cnt = 0; m_ffv = 1'b0; m_ffvec = 4'd0;
    end else begin
      m_sv = 1'b0;
      m_sf = 1'b0;
      if (m_active) begin
        m_k = m_k + 1;
        if (m_k % H == 0) begin
          m_s  = 4'(((m_k / H) - 1) % NV);
          m_sv = 1'b1;
          m_sf = (faulty(m_s, fault) != gold(m_s));
          if (m_sf) begin
            if (m_cnt < 31) m_cnt = m_cnt + 1;
            if (!m_ffv) begin
              m_ffv   = 1'b1;
              m_ffvec = m_s;
            end
          end
          if (m_s == 4'(NV - 1) && !loop) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
        if (m_active) m_vec = 4'((m_k / H) % NV);
      end else if (start) begin
        m_active = 1'b1; m_done = 1'b0; m_k = 0; m_vec = 4'd0;
        m_cnt = 0; m_ffv = 1'b0; m_ffvec = 4'd0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every u1 output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("vec_out", 32'(vec), 32'(m_vec));
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_done));
      check("sample_valid", 32'(sv), 32'(m_sv));
      check("sample_fail", 32'(sf), 32'(m_sf));
      check("mismatch_cnt", 32'(cnt), 32'(m_cnt));
      check("first_fail_valid", 32'(ffv), 32'(m_ffv));
      check("first_fail_vec", 32'(ffvec), 32'(m_ffvec));
    end
  end

  task automatic clr_counts();
    busy_cnt = 0; samp_cnt = 0; done_seen = 0; busy2_cnt = 0; samp2_cnt = 0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy)  busy_cnt++;
      if (sv)    samp_cnt++;
      if (done)  done_seen++;
      if (busy2) busy2_cnt++;
      if (sv2)   samp2_cnt++;
    end
  endtask

  task automatic kick();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  logic [3:0] seq2;

  initial begin
    n_tests = 0; n_fail = 0; chk_en = 1'b0;
    rst = 1'b1; start = 1'b0; loop = 1'b0; fault = 0;
    start2 = 1'b0; loop2 = 1'b0;
    clr_counts();
    step(3);
    check("reset vec_out", 32'(vec), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sample_valid", 32'(sv), 32'd0);
    check("reset mismatch_cnt", 32'(cnt), 32'd0);
    check("reset first_fail_valid", 32'(ffv), 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    step(2);

    // 1: clean sweep
    clr_counts();
    kick();
    step(70);
    check("s1 busy cycles", 32'(busy_cnt), 32'd64);
    check("s1 samples", 32'(samp_cnt), 32'd16);
    check("s1 done", 32'(done), 32'd1);
    check("s1 mismatch_cnt", 32'(cnt), 32'd0);
    check("s1 first_fail_valid", 32'(ffv), 32'd0);

    // 2: f stuck-at-0
    fault = 1;
    kick();
    step(70);
    check("s2 mismatch_cnt", 32'(cnt), 32'd4);
    check("s2 first_fail_vec", 32'(ffvec), 32'hC);
    check("s2 first_fail_valid", 32'(ffv), 32'd1);

    // 3: reset at cycle 30 mid-sweep
    fault = 2;
    kick();
    step(29);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("s3 vec_out", 32'(vec), 32'd0);
    check("s3 busy", 32'(busy), 32'd0);
    check("s3 done", 32'(done), 32'd0);
    check("s3 mismatch_cnt", 32'(cnt), 32'd0);
    clr_counts();
    step(10);
    check("s3 no samples", 32'(samp_cnt), 32'd0);
    fault = 0;
    clr_counts();
    kick();
    step(70);
    check("s3 busy cycles", 32'(busy_cnt), 32'd64);
    check("s3 samples", 32'(samp_cnt), 32'd16);

    // 4: looping with every vector failing
    fault = 2;
    loop = 1'b1;
    clr_counts();
    kick();
    step(192);
    check("s4 no done", 32'(done_seen), 32'd0);
    check("s4 still busy", 32'(busy), 32'd1);
    check("s4 mismatch_cnt", 32'(cnt), 32'd31);
    check("s4 first_fail_vec", 32'(ffvec), 32'd0);
    check("s4 samples", 32'(samp_cnt), 32'd48);
    loop = 1'b0;
    step(70);
    check("s4 done", 32'(done), 32'd1);
    check("s4 final vec", 32'(vec), 32'hF);

    // 5: start ignored in DRIVE, honoured in DONE
    fault = 1;
    clr_counts();
    kick();
    step(9);
    kick();
    step(60);
    check("s5 busy cycles", 32'(busy_cnt), 32'd64);
    check("s5 mismatch_cnt", 32'(cnt), 32'd4);
    check("s5 done", 32'(done), 32'd1);
    kick();
    check("s5 restart cnt clear", 32'(cnt), 32'd0);
    check("s5 restart ffv clear", 32'(ffv), 32'd0);
    check("s5 restart busy", 32'(busy), 32'd1);
    step(70);
    check("s5 second cnt", 32'(cnt), 32'd4);
    check("s5 second first_fail_vec", 32'(ffvec), 32'hC);

    // 6: N_IN=1, HOLD=2 instance
    clr_counts();
    start2 = 1'b1;
    step(1);
    start2 = 1'b0;
    seq2[0] = vec2;
    step(1);
    seq2[1] = vec2;
    step(1);
    seq2[2] = vec2;
    step(1);
    seq2[3] = vec2;
    check("s6 not done yet", 32'(done2), 32'd0);
    step(1);
    check("s6 vec sequence", 32'(seq2), 32'hC);
    check("s6 done", 32'(done2), 32'd1);
    step(3);
    check("s6 samples", 32'(samp2_cnt), 32'd2);
    check("s6 busy cycles", 32'(busy2_cnt), 32'd4);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
